// File: rtl/blink_sched_pkg.sv
// rtl/blink_sched_pkg.sv - shared state and source encodings for the blink scheduler
package blink_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        FLUSH = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_OK   = 2'd1;
    localparam logic [1:0] SRC_ERR  = 2'd2;
    localparam logic [1:0] SRC_ALM  = 2'd3;

endpackage

// File: rtl/sched_prio_enc.sv
// rtl/sched_prio_enc.sv - fixed-priority encoder, ALARM over ERR over OK
module sched_prio_enc
    import blink_sched_pkg::*;
(
    input  logic [2:0] pending,
    output logic [1:0] grant,
    output logic       valid
);

    // pending is {alarm, err, ok}
    always_comb begin
        grant = SRC_NONE;
        valid = 1'b1;
        if (pending[2]) begin
            grant = SRC_ALM;
        end else if (pending[1]) begin
            grant = SRC_ERR;
        end else if (pending[0]) begin
            grant = SRC_OK;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/blink_scheduler.sv
// rtl/blink_scheduler.sv - request latch, priority grant and pattern sequencing for the blink engine
module blink_scheduler
    import blink_sched_pkg::*;
#(
    parameter logic [4:0]  OK_ON          = 5'd5,
    parameter logic [4:0]  OK_OFF         = 5'd5,
    parameter logic [2:0]  OK_REP         = 3'd2,
    parameter logic [4:0]  ERR_ON         = 5'd2,
    parameter logic [4:0]  ERR_OFF        = 5'd2,
    parameter logic [2:0]  ERR_REP        = 3'd3,
    parameter logic [4:0]  ALM_ON         = 5'd10,
    parameter logic [4:0]  ALM_OFF        = 5'd10,
    parameter logic [2:0]  ALM_REP        = 3'd7,
    parameter logic [31:0] GAP_CYCLES     = 32'd2400000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd600000000,
    parameter logic        PREEMPT        = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_OK,
    input  logic       REQ_ERR,
    input  logic       REQ_ALARM,
    input  logic       BLINK_DONE,
    output logic       BLINK_GO,
    output logic       BLINK_RST,
    output logic [4:0] BLINK_ON,
    output logic [4:0] BLINK_OFF,
    output logic [2:0] BLINK_REPEAT,
    output logic       BUSY,
    output logic [1:0] ACTIVE,
    output logic       ERR_TIMEOUT
);

    state_t      state;
    logic [2:0]  pend;
    logic [31:0] wd_cnt;
    logic [31:0] gap_cnt;
    logic [1:0]  grant;
    logic        grant_valid;
    logic        issue_now;
    logic [2:0]  grant_clr;
    logic [2:0]  req_vec;
    logic        gap_last;
    logic        wd_last;
    logic        preempt;
    logic [4:0]  pat_on;
    logic [4:0]  pat_off;
    logic [2:0]  pat_rep;

    sched_prio_enc u_prio_enc (
        .pending (pend),
        .grant   (grant),
        .valid   (grant_valid)
    );

    assign req_vec   = {REQ_ALARM, REQ_ERR, REQ_OK};
    assign BUSY      = (state != IDLE);
    assign gap_last  = (GAP_CYCLES == 32'd0) || (gap_cnt == GAP_CYCLES - 32'd1);
    assign wd_last   = (wd_cnt == TIMEOUT_CYCLES - 32'd1);
    assign preempt   = PREEMPT && pend[2] && (ACTIVE != SRC_ALM);
    // The grant is taken on the edge into ISSUE so GO and the pattern appear together.
    assign issue_now = ((state == IDLE) || (state == FLUSH)) && grant_valid;

    always_comb begin
        grant_clr = 3'b000;
        if (issue_now) begin
            case (grant)
                SRC_OK:  grant_clr = 3'b001;
                SRC_ERR: grant_clr = 3'b010;
                SRC_ALM: grant_clr = 3'b100;
                default: grant_clr = 3'b000;
            endcase
        end
    end

    always_comb begin
        pat_on  = OK_ON;
        pat_off = OK_OFF;
        pat_rep = OK_REP;
        case (grant)
            SRC_ERR: begin
                pat_on  = ERR_ON;
                pat_off = ERR_OFF;
                pat_rep = ERR_REP;
            end
            SRC_ALM: begin
                pat_on  = ALM_ON;
                pat_off = ALM_OFF;
                pat_rep = ALM_REP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            pend         <= 3'b000;
            wd_cnt       <= 32'd0;
            gap_cnt      <= 32'd0;
            BLINK_GO     <= 1'b0;
            BLINK_RST    <= 1'b0;
            BLINK_ON     <= 5'd0;
            BLINK_OFF    <= 5'd0;
            BLINK_REPEAT <= 3'd0;
            ACTIVE       <= SRC_NONE;
            ERR_TIMEOUT  <= 1'b0;
        end else begin
            // A request in the grant cycle survives the clear and is serviced again.
            pend      <= (pend & ~grant_clr) | req_vec;
            BLINK_GO  <= 1'b0;
            BLINK_RST <= 1'b0;

            if (issue_now) begin
                state        <= ISSUE;
                BLINK_GO     <= 1'b1;
                ACTIVE       <= grant;
                BLINK_ON     <= pat_on;
                BLINK_OFF    <= pat_off;
                BLINK_REPEAT <= pat_rep;
            end else begin
                case (state)
                    IDLE: ;
                    ISSUE: begin
                        state  <= WAIT;
                        wd_cnt <= 32'd0;
                    end
                    WAIT: begin
                        wd_cnt <= wd_cnt + 32'd1;
                        if (BLINK_DONE) begin
                            state   <= GAP;
                            gap_cnt <= 32'd0;
                            wd_cnt  <= 32'd0;
                        end else if (preempt) begin
                            state     <= FLUSH;
                            BLINK_RST <= 1'b1;
                        end else if (wd_last) begin
                            state       <= GAP;
                            gap_cnt     <= 32'd0;
                            BLINK_RST   <= 1'b1;
                            ERR_TIMEOUT <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        state  <= IDLE;
                        ACTIVE <= SRC_NONE;
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt + 32'd1;
                        if (gap_last) begin
                            state  <= IDLE;
                            ACTIVE <= SRC_NONE;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        ACTIVE <= SRC_NONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blink_scheduler.sv
// tb/tb_blink_scheduler.sv - self-checking bench for blink_scheduler with a behavioural engine
module tb_blink_scheduler;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_OK = 1'b0;
    logic       REQ_ERR = 1'b0;
    logic       REQ_ALARM = 1'b0;
    logic       BLINK_DONE = 1'b0;
    logic       BLINK_GO;
    logic       BLINK_RST;
    logic [4:0] BLINK_ON;
    logic [4:0] BLINK_OFF;
    logic [2:0] BLINK_REPEAT;
    logic       BUSY;
    logic [1:0] ACTIVE;
    logic       ERR_TIMEOUT;

    blink_scheduler #(
        .GAP_CYCLES     (32'd4),
        .TIMEOUT_CYCLES (32'd50)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .REQ_OK       (REQ_OK),
        .REQ_ERR      (REQ_ERR),
        .REQ_ALARM    (REQ_ALARM),
        .BLINK_DONE   (BLINK_DONE),
        .BLINK_GO     (BLINK_GO),
        .BLINK_RST    (BLINK_RST),
        .BLINK_ON     (BLINK_ON),
        .BLINK_OFF    (BLINK_OFF),
        .BLINK_REPEAT (BLINK_REPEAT),
        .BUSY         (BUSY),
        .ACTIVE       (ACTIVE),
        .ERR_TIMEOUT  (ERR_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] active;
        logic [4:0] on;
        logic [4:0] off;
        logic [2:0] rep;
        int         go_cyc;
    } exp_t;

    typedef struct {
        logic [2:0] req;
        logic [1:0] active;
        logic [4:0] on;
        logic [4:0] off;
        logic [2:0] rep;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[3];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int done_at = -1;
    bit hang = 1'b0;
    int rst_count = 0;
    int last_rst_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] a, input logic [4:0] on, input logic [4:0] off,
                            input logic [2:0] rep, input int go_cyc);
        exp_t e;
        e.active = a;
        e.on     = on;
        e.off    = off;
        e.rep    = rep;
        e.go_cyc = go_cyc;
        exp_q.push_back(e);
    endtask

    task automatic observe();
        exp_t e;
        if (BLINK_GO === 1'b1) begin
            done_at = hang ? -1 : cyc + 20;
            if (BLINK_RST === 1'b1) chk("go_with_rst", 1, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_go_active", ACTIVE, 0);
                chk("unexpected_go", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("go_active", ACTIVE, e.active);
                chk("go_on", BLINK_ON, e.on);
                chk("go_off", BLINK_OFF, e.off);
                chk("go_repeat", BLINK_REPEAT, e.rep);
                chk("go_cycle", cyc, e.go_cyc);
            end
        end
        if (BLINK_RST === 1'b1) begin
            rst_count++;
            last_rst_cyc = cyc;
            done_at = -1;
        end
    endtask

    // Drive the inputs of the current cycle, clock once, sample at the falling edge.
    task automatic step(input logic [2:0] req, input logic rst);
        {REQ_ALARM, REQ_ERR, REQ_OK} = req;
        RST        = rst;
        BLINK_DONE = (!hang && cyc == done_at);
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        observe();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 1'b0);
    endtask

    task automatic wait_idle(input string name, input int limit, output int idle_cyc);
        int n;
        n = 0;
        while (BUSY !== 1'b1 && n < limit) begin
            step(3'b000, 1'b0);
            n++;
        end
        while (BUSY !== 1'b0 && n < limit) begin
            step(3'b000, 1'b0);
            n++;
        end
        idle_cyc = cyc;
        if (n >= limit) begin
            checks++;
            errors++;
            $display("FAIL %s: no return to idle within %0d cycles", name, limit);
        end
    endtask

    initial begin
        int t;
        int idle_c;
        int busy_cnt;

        vecs[0] = '{req: 3'b001, active: 2'd1, on: 5'd5,  off: 5'd5,  rep: 3'd2};
        vecs[1] = '{req: 3'b010, active: 2'd2, on: 5'd2,  off: 5'd2,  rep: 3'd3};
        vecs[2] = '{req: 3'b100, active: 2'd3, on: 5'd10, off: 5'd10, rep: 3'd7};

        @(negedge CLK);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        chk("reset_busy", BUSY, 0);
        chk("reset_active", ACTIVE, 0);
        chk("reset_go", BLINK_GO, 0);
        chk("reset_blink_rst", BLINK_RST, 0);
        chk("reset_on", BLINK_ON, 0);
        chk("reset_off", BLINK_OFF, 0);
        chk("reset_repeat", BLINK_REPEAT, 0);
        chk("reset_timeout", ERR_TIMEOUT, 0);
        run(4);

        // Single-source patterns: GO two cycles after REQ, idle 25 cycles after GO.
        for (int i = 0; i < 3; i++) begin
            t = cyc;
            push_exp(vecs[i].active, vecs[i].on, vecs[i].off, vecs[i].rep, t + 2);
            step(vecs[i].req, 1'b0);
            wait_idle("single", 60, idle_c);
            chk("single_idle_cycle", idle_c, t + 27);
            chk("single_active_cleared", ACTIVE, 0);
            run(3);
        end

        // All three at once: strict priority order, GOs 26 cycles apart.
        t = cyc;
        push_exp(2'd3, 5'd10, 5'd10, 3'd7, t + 2);
        push_exp(2'd2, 5'd2,  5'd2,  3'd3, t + 28);
        push_exp(2'd1, 5'd5,  5'd5,  3'd2, t + 54);
        step(3'b111, 1'b0);
        run(90);
        chk("simul_all_served", exp_q.size(), 0);

        // Preempt: ALARM arrives 5 cycles after the ERR GO.
        rst_count = 0;
        t = cyc;
        push_exp(2'd2, 5'd2, 5'd2, 3'd3, t + 2);
        push_exp(2'd3, 5'd10, 5'd10, 3'd7, t + 10);
        step(3'b010, 1'b0);
        run(6);
        step(3'b100, 1'b0);
        wait_idle("preempt", 80, idle_c);
        chk("preempt_rst_count", rst_count, 1);
        chk("preempt_rst_cycle", last_rst_cyc, t + 9);
        chk("preempt_idle_cycle", idle_c, t + 35);
        run(30);
        chk("preempt_err_dropped", exp_q.size(), 0);

        // Watchdog: engine never answers.
        hang = 1'b1;
        rst_count = 0;
        t = cyc;
        push_exp(2'd1, 5'd5, 5'd5, 3'd2, t + 2);
        step(3'b001, 1'b0);
        run(55);
        chk("timeout_rst_count", rst_count, 1);
        chk("timeout_rst_cycle", last_rst_cyc, t + 53);
        chk("timeout_flag", ERR_TIMEOUT, 1);
        run(3);
        chk("timeout_idle", BUSY, 0);
        hang = 1'b0;
        t = cyc;
        push_exp(2'd2, 5'd2, 5'd2, 3'd3, t + 2);
        step(3'b010, 1'b0);
        wait_idle("after_timeout", 60, idle_c);
        chk("timeout_sticky", ERR_TIMEOUT, 1);

        // Re-request of OK in its own ISSUE cycle gives a second service.
        run(3);
        t = cyc;
        push_exp(2'd1, 5'd5, 5'd5, 3'd2, t + 2);
        push_exp(2'd1, 5'd5, 5'd5, 3'd2, t + 28);
        step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        step(3'b001, 1'b0);
        run(60);
        chk("rereq_served_twice", exp_q.size(), 0);

        // Reset in the middle of WAIT with an ERR request pending.
        rst_count = 0;
        t = cyc;
        push_exp(2'd1, 5'd5, 5'd5, 3'd2, t + 2);
        step(3'b001, 1'b0);
        run(6);
        step(3'b010, 1'b0);
        step(3'b000, 1'b1);
        chk("midreset_busy", BUSY, 0);
        chk("midreset_active", ACTIVE, 0);
        chk("midreset_go", BLINK_GO, 0);
        chk("midreset_timeout", ERR_TIMEOUT, 0);
        chk("midreset_repeat", BLINK_REPEAT, 0);
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(3'b000, 1'b0);
            if (BUSY !== 1'b0) busy_cnt++;
        end
        chk("midreset_stays_idle", busy_cnt, 0);
        chk("midreset_no_blink_rst", rst_count, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
